jt900h_rbank: RTL and testbench
===============================

# jt900h_rbank

Parametrised banked register file for the JT900H core: the next generation of the register storage, with configurable bank count, accumulators per bank and shared pointer count. It keeps byte, word and long lane-addressed writes and adds two read ports with sign/zero extension, bank-pointer increment/decrement with wrap-around, and a handshaked serial dump engine. It sits between the micro-sequencer/ALU and the memory unit, and is clock-enabled by the core `cen`.

## Interface
Parameters:
- NBANK, 4, number of register banks; power of two, minimum 2. BW=log2(NBANK).
- NACC, 4, accumulators per bank; power of two. IW=log2(max(NACC,NPTR)).
- NPTR, 4, shared pointer registers; power of two, at most 1<<IW.
- SP_RST, 32'h100, reset value of pointer NPTR-1 (stack pointer).
- RW, 1+BW+IW+2 (derived), register code width: {is_ptr, bank, index, lane[1:0]}.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cen  in  1  clock enable; all state changes require cen=1
- rd0_addr, rd1_addr  in  RW  read codes
- rd0_cur, rd1_cur  in  1  replace the bank field with rfp
- rd0_prv, rd1_prv  in  1  replace the bank field with rfp-1 (mod NBANK); ignored if *_cur=1
- rd_size  in  2  0 byte, 1 word, 2 long (shared by both read ports)
- rd_sex, rd_zex  in  1  sign/zero-extend the read result; sex wins if both are set
- rd0_data, rd1_data  out  32  lane-shifted, extended read data
- we  in  1  write strobe
- wr_addr  in  RW  write code; wr_cur and wr_prv apply as on the read ports
- wr_cur, wr_prv  in  1  bank substitution for writes
- wr_size  in  2  0 byte, 1 word, 2 long
- wr_data  in  32  write data, right-aligned
- rfp_ld  in  1  load the bank pointer from rfp_din
- rfp_din  in  BW  new bank pointer
- rfp_inc, rfp_dec  in  1  INCF/DECF
- rfp  out  BW  current bank pointer
- xsp  out  32  pointer NPTR-1, live
- dmp_start  in  1  start a dump
- dmp_valid  out  1  dump byte available
- dmp_ready  in  1  consumer accepts the byte
- dmp_dout  out  8  dump byte
- dmp_last  out  1  marks the final dump byte
- dmp_busy  out  1  dump in progress

## Operation
Register selection:
- A code with is_ptr=1 selects ptrs[index]; the bank field is ignored.
- Otherwise the code selects accs[bank][index]. An index ≥ NACC (or ≥ NPTR for pointers) reads 0 and ignores writes.

Read, combinational:
- The selected 32-bit register is shifted right by lane*8 for byte, by lane[1]*16 for word, and by 0 for long.
- Byte/word results are sign- or zero-extended to 32 bits. With neither flag set, the upper bits are the shifted-in register bits.

Write, on a cen edge with we=1:
- Byte writes wr_data[7:0] into the lane.
- Word writes wr_data[15:0] into half lane[1]; lane[0] is ignored.
- Long writes all 32 bits; lane is ignored.
- wr_size=3 is a no-op.

Bank pointer:
- Priority is rfp_ld > (rfp_inc xor rfp_dec).
- inc and dec together with no ld leaves rfp unchanged.
- Arithmetic is mod NBANK: NBANK-1+1 gives 0, and 0-1 gives NBANK-1.
- wr_cur/rd_cur use the rfp value from before the edge.

Dump FSM (states IDLE, SEND):
- IDLE: dmp_start on a cen cycle moves to SEND with byte index 0. dmp_start while in SEND is ignored.
- Byte order: accs[bank 0..NBANK-1][index 0..NACC-1] LSB first, then ptrs[0..NPTR-1] LSB first, then one status byte {0, rfp}.
- Total bytes N = 4*(NBANK*NACC+NPTR)+1, which is 81 at default parameters.
- In SEND, dmp_valid=1. A cen cycle with dmp_ready=1 advances the index. dmp_dout is held stable while ready=0.
- dmp_last=1 while index=N-1. Accepting that byte returns the FSM to IDLE.
- Data is live, not a snapshot: a write during the dump is reflected if its byte has not been sent yet.

Reset values:
- All accs 0; ptrs 0 except ptrs[NPTR-1]=SP_RST.
- rfp=0, FSM IDLE, dmp_valid=0, dmp_last=0, dmp_busy=0.
- Read outputs follow the array: 0, except for a code that selects xsp.
- Reset mid-dump aborts the dump immediately with no further bytes.

## Timing
- Reads have zero latency. A read of the register being written in the same cycle returns the old value; the new value is visible after the edge (no bypass).
- rfp and xsp update one cycle after the strobe.
- Dump: dmp_start sampled on cycle t gives dmp_valid=1 and dmp_busy=1 at t+1 with byte 0. The fastest stream is one byte per cen cycle. After the last byte is accepted on cycle u, dmp_valid=0 and dmp_busy=0 at u+1.
- A new dmp_start is accepted from u+1.
- When cen=0, all state freezes, including the dump index, even if dmp_ready=1.

## Test plan
- Lane writes, default parameters: long write 32'h11223344 to accs[1][2]; byte write 8'hAA at lane 2 -> long read 32'h11AA3344; word read at lane 2 with sex -> 32'h000011AA; byte read at lane 2 with sex -> 32'hFFFFFFAA.
- Bank pointer wrap: rfp=3, rfp_inc -> 0; rfp_dec -> 3; rfp_inc=rfp_dec=1 -> stays 3; rfp_ld with din=1 and inc=1 together -> 1.
- Current/previous bank: rfp=0; wr_prv long write 5 to index 0 -> accs[3][0]=5; rd0_cur at index 0 -> 0; rd0_prv at index 0 -> 5.
- Reset: after rst, xsp=32'h100 and all dumped bytes are 0 except bytes 76 and 77, which give the xsp bytes 00 and 01; rst asserted mid-dump drops dmp_valid immediately.
- Dump backpressure: dmp_ready toggled 1/0 every cycle -> exactly 81 bytes, no duplicate or skipped byte, dmp_last on byte 80 only, last byte = rfp; dmp_start during the dump is ignored.
- Non-default NBANK=8, NACC=8, NPTR=2: rfp wraps 7->0; dump length is 4*(64+2)+1=265 bytes; index 3 on a pointer code reads 0.

Source files
------------

// File: rtl/jt900h_rbank.sv
// jt900h_rbank: banked accumulator/pointer register file for the JT900H core with
// two extending read ports, bank-pointer arithmetic and a handshaked byte dump.
module jt900h_rbank #(
   parameter int          NBANK  = 4,
   parameter int          NACC   = 4,
   parameter int          NPTR   = 4,
   parameter logic [31:0] SP_RST = 32'h100,
   localparam int         BW     = $clog2(NBANK),
   localparam int         IW     = $clog2((NACC > NPTR) ? NACC : NPTR),
   localparam int         RW     = 1 + BW + IW + 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cen,
   input  logic [RW-1:0] rd0_addr,
   input  logic [RW-1:0] rd1_addr,
   input  logic          rd0_cur,
   input  logic          rd1_cur,
   input  logic          rd0_prv,
   input  logic          rd1_prv,
   input  logic [1:0]    rd_size,
   input  logic          rd_sex,
   input  logic          rd_zex,
   output logic [31:0]   rd0_data,
   output logic [31:0]   rd1_data,
   input  logic          we,
   input  logic [RW-1:0] wr_addr,
   input  logic          wr_cur,
   input  logic          wr_prv,
   input  logic [1:0]    wr_size,
   input  logic [31:0]   wr_data,
   input  logic          rfp_ld,
   input  logic [BW-1:0] rfp_din,
   input  logic          rfp_inc,
   input  logic          rfp_dec,
   output logic [BW-1:0] rfp,
   output logic [31:0]   xsp,
   input  logic          dmp_start,
   output logic          dmp_valid,
   input  logic          dmp_ready,
   output logic [7:0]    dmp_dout,
   output logic          dmp_last,
   output logic          dmp_busy
);
   localparam int NREG = NBANK * NACC + NPTR;
   localparam int NDMP = 4 * NREG + 1;
   localparam int DW   = $clog2(NDMP);

   typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} dmp_state_t;

   logic [31:0]   accs_q [NBANK][NACC];
   logic [31:0]   accs_d [NBANK][NACC];
   logic [31:0]   ptrs_q [NPTR];
   logic [31:0]   ptrs_d [NPTR];
   logic [BW-1:0] rfp_q, rfp_d;
   dmp_state_t    dmp_state_q, dmp_state_d;
   logic [DW-1:0] dmp_idx_q, dmp_idx_d;

   logic [RW-1:0] rd_addr_s [2];
   logic [1:0]    rd_cur_s, rd_prv_s;
   logic [BW-1:0] rd_bank_s [2];
   logic [31:0]   rd_reg_s  [2];
   logic [BW-1:0] wr_bank_s;
   logic [31:0]   dmp_word_s;

   function automatic logic [BW-1:0] bank_sel(input logic [BW-1:0] fld, input logic cur,
                                              input logic prv, input logic [BW-1:0] ptr);
      logic [BW-1:0] b;
      if (cur)      b = ptr;
      else if (prv) b = ptr - BW'(1);
      else          b = fld;
      return b;
   endfunction

   function automatic logic [31:0] read_ext(input logic [31:0] r, input logic [1:0] lane,
                                            input logic [1:0] size, input logic sex, input logic zex);
      logic [31:0] s;
      case (size)
         2'd0:    s = r >> {lane, 3'b000};
         2'd1:    s = r >> {lane[1], 4'b0000};
         default: s = r;
      endcase
      // Without an extension flag the shifted-in register bits are kept above the lane
      if (size == 2'd0 && (sex || zex))      s = {{24{sex & s[7]}}, s[7:0]};
      else if (size == 2'd1 && (sex || zex)) s = {{16{sex & s[15]}}, s[15:0]};
      return s;
   endfunction

   function automatic logic [31:0] wr_merge(input logic [31:0] r, input logic [31:0] d,
                                            input logic [1:0] lane, input logic [1:0] size);
      logic [31:0] m;
      m = r;
      case (size)
         2'd0:    m[{lane, 3'b000} +: 8]     = d[7:0];
         2'd1:    m[{lane[1], 4'b0000} +: 16] = d[15:0];
         2'd2:    m = d;
         default: m = r;
      endcase
      return m;
   endfunction

   assign rd_addr_s[0] = rd0_addr;
   assign rd_addr_s[1] = rd1_addr;
   assign rd_cur_s     = {rd1_cur, rd0_cur};
   assign rd_prv_s     = {rd1_prv, rd0_prv};

   // Read ports: out-of-range indices fall through to the zero default
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rd_reg_s[p]  = 32'h0;
         rd_bank_s[p] = bank_sel(rd_addr_s[p][RW-2 -: BW], rd_cur_s[p], rd_prv_s[p], rfp_q);
         for (int i = 0; i < NPTR; i++)
            rd_reg_s[p] = (rd_addr_s[p][RW-1] && rd_addr_s[p][IW+1:2] == IW'(i)) ? ptrs_q[i] : rd_reg_s[p];
         for (int b = 0; b < NBANK; b++)
            for (int a = 0; a < NACC; a++)
               rd_reg_s[p] = (!rd_addr_s[p][RW-1] && rd_bank_s[p] == BW'(b) && rd_addr_s[p][IW+1:2] == IW'(a))
                             ? accs_q[b][a] : rd_reg_s[p];
      end
      rd0_data = read_ext(rd_reg_s[0], rd0_addr[1:0], rd_size, rd_sex, rd_zex);
      rd1_data = read_ext(rd_reg_s[1], rd1_addr[1:0], rd_size, rd_sex, rd_zex);
   end

   // Lane-merged write into the addressed register
   always_comb begin
      wr_bank_s = bank_sel(wr_addr[RW-2 -: BW], wr_cur, wr_prv, rfp_q);
      accs_d    = accs_q;
      ptrs_d    = ptrs_q;
      for (int i = 0; i < NPTR; i++)
         ptrs_d[i] = (we && wr_addr[RW-1] && wr_addr[IW+1:2] == IW'(i))
                     ? wr_merge(ptrs_q[i], wr_data, wr_addr[1:0], wr_size) : ptrs_q[i];
      for (int b = 0; b < NBANK; b++)
         for (int a = 0; a < NACC; a++)
            accs_d[b][a] = (we && !wr_addr[RW-1] && wr_bank_s == BW'(b) && wr_addr[IW+1:2] == IW'(a))
                           ? wr_merge(accs_q[b][a], wr_data, wr_addr[1:0], wr_size) : accs_q[b][a];
   end

   // Bank pointer: load beats a single inc or dec; the power-of-two width gives the wrap
   always_comb begin
      if (rfp_ld)                    rfp_d = rfp_din;
      else if (rfp_inc && !rfp_dec)  rfp_d = rfp_q + BW'(1);
      else if (rfp_dec && !rfp_inc)  rfp_d = rfp_q - BW'(1);
      else                           rfp_d = rfp_q;
   end

   // Dump sequencer next state
   always_comb begin
      dmp_state_d = dmp_state_q;
      dmp_idx_d   = dmp_idx_q;
      case (dmp_state_q)
         S_IDLE: begin
            if (dmp_start) begin
               dmp_state_d = S_SEND;
               dmp_idx_d   = {DW{1'b0}};
            end else begin
               dmp_idx_d   = dmp_idx_q;
            end
         end
         S_SEND: begin
            if (dmp_ready && dmp_idx_q == DW'(NDMP - 1)) dmp_state_d = S_IDLE;
            else if (dmp_ready)                          dmp_idx_d   = dmp_idx_q + DW'(1);
            else                                         dmp_idx_d   = dmp_idx_q;
         end
         default: dmp_state_d = S_IDLE;
      endcase
   end

   // Live dump byte: accumulators, then pointers, then the bank-pointer status byte
   always_comb begin
      dmp_word_s = 32'h0;
      for (int b = 0; b < NBANK; b++)
         for (int a = 0; a < NACC; a++)
            dmp_word_s = (dmp_idx_q[DW-1:2] == (DW-2)'(b * NACC + a)) ? accs_q[b][a] : dmp_word_s;
      for (int i = 0; i < NPTR; i++)
         dmp_word_s = (dmp_idx_q[DW-1:2] == (DW-2)'(NBANK * NACC + i)) ? ptrs_q[i] : dmp_word_s;
      if (dmp_idx_q == DW'(NDMP - 1)) dmp_dout = {{(8-BW){1'b0}}, rfp_q};
      else                            dmp_dout = dmp_word_s[{dmp_idx_q[1:0], 3'b000} +: 8];
   end

   // State registers, frozen while cen is low
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < NBANK; b++)
            for (int a = 0; a < NACC; a++)
               accs_q[b][a] <= 32'h0;
         for (int i = 0; i < NPTR; i++)
            ptrs_q[i] <= (i == NPTR - 1) ? SP_RST : 32'h0;
         rfp_q       <= {BW{1'b0}};
         dmp_state_q <= S_IDLE;
         dmp_idx_q   <= {DW{1'b0}};
      end else if (cen) begin
         accs_q      <= accs_d;
         ptrs_q      <= ptrs_d;
         rfp_q       <= rfp_d;
         dmp_state_q <= dmp_state_d;
         dmp_idx_q   <= dmp_idx_d;
      end
   end

   assign rfp       = rfp_q;
   assign xsp       = ptrs_q[NPTR-1];
   assign dmp_valid = (dmp_state_q == S_SEND);
   assign dmp_busy  = (dmp_state_q == S_SEND);
   assign dmp_last  = (dmp_state_q == S_SEND) && (dmp_idx_q == DW'(NDMP - 1));

endmodule

// File: tb/tb_jt900h_rbank.sv
// Self-checking bench for jt900h_rbank: directed cases plus randomized traffic
// compared against a behavioural model of the register file and dump stream.
module tb_jt900h_rbank;
   localparam int NB = 4, NA = 4, NP = 4, RW = 7, ND = 81;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, cen;
   logic [RW-1:0] rd0_addr, rd1_addr, wr_addr;
   logic rd0_cur, rd1_cur, rd0_prv, rd1_prv, rd_sex, rd_zex, we, wr_cur, wr_prv;
   logic [1:0] rd_size, wr_size, rfp_din, rfp;
   logic [31:0] rd0_data, rd1_data, wr_data, xsp;
   logic rfp_ld, rfp_inc, rfp_dec, dmp_start, dmp_valid, dmp_ready, dmp_last, dmp_busy;
   logic [7:0] dmp_dout;

   jt900h_rbank dut (
      .clk(clk), .rst(rst), .cen(cen),
      .rd0_addr(rd0_addr), .rd1_addr(rd1_addr), .rd0_cur(rd0_cur), .rd1_cur(rd1_cur),
      .rd0_prv(rd0_prv), .rd1_prv(rd1_prv), .rd_size(rd_size), .rd_sex(rd_sex), .rd_zex(rd_zex),
      .rd0_data(rd0_data), .rd1_data(rd1_data), .we(we), .wr_addr(wr_addr), .wr_cur(wr_cur),
      .wr_prv(wr_prv), .wr_size(wr_size), .wr_data(wr_data), .rfp_ld(rfp_ld), .rfp_din(rfp_din),
      .rfp_inc(rfp_inc), .rfp_dec(rfp_dec), .rfp(rfp), .xsp(xsp), .dmp_start(dmp_start),
      .dmp_valid(dmp_valid), .dmp_ready(dmp_ready), .dmp_dout(dmp_dout), .dmp_last(dmp_last),
      .dmp_busy(dmp_busy)
   );

   // Second instance at NBANK=8, NACC=8, NPTR=2
   logic [8:0] b_rd0_addr, b_wr_addr;
   logic [2:0] b_rfp_din, b_rfp;
   logic [31:0] b_rd0_data, b_rd1_data, b_wr_data, b_xsp;
   logic b_we, b_rfp_ld, b_rfp_inc, b_dmp_start, b_dmp_ready, b_dmp_valid, b_dmp_last, b_dmp_busy;
   logic [7:0] b_dmp_dout;

   jt900h_rbank #(.NBANK(8), .NACC(8), .NPTR(2)) dut_b (
      .clk(clk), .rst(rst), .cen(1'b1),
      .rd0_addr(b_rd0_addr), .rd1_addr(9'h0), .rd0_cur(1'b0), .rd1_cur(1'b0),
      .rd0_prv(1'b0), .rd1_prv(1'b0), .rd_size(2'd2), .rd_sex(1'b0), .rd_zex(1'b0),
      .rd0_data(b_rd0_data), .rd1_data(b_rd1_data), .we(b_we), .wr_addr(b_wr_addr), .wr_cur(1'b0),
      .wr_prv(1'b0), .wr_size(2'd2), .wr_data(b_wr_data), .rfp_ld(b_rfp_ld), .rfp_din(b_rfp_din),
      .rfp_inc(b_rfp_inc), .rfp_dec(1'b0), .rfp(b_rfp), .xsp(b_xsp), .dmp_start(b_dmp_start),
      .dmp_valid(b_dmp_valid), .dmp_ready(b_dmp_ready), .dmp_dout(b_dmp_dout), .dmp_last(b_dmp_last),
      .dmp_busy(b_dmp_busy)
   );

   logic [31:0] m_acc [NB][NA];
   logic [31:0] m_ptr [NP];
   int m_rfp, m_idx;
   bit m_busy;
   int n_cmp = 0, n_err = 0;
   logic [7:0] dq[$];
   int nlast, lastpos;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int b = 0; b < NB; b++)
         for (int a = 0; a < NA; a++)
            m_acc[b][a] = 32'h0;
      for (int i = 0; i < NP; i++) m_ptr[i] = 32'h0;
      m_ptr[NP-1] = 32'h100;
      m_rfp = 0; m_busy = 1'b0; m_idx = 0;
   endtask

   function automatic int eff_bank(input int fld, input bit cur, input bit prv);
      if (cur) return m_rfp;
      if (prv) return (m_rfp + NB - 1) % NB;
      return fld;
   endfunction

   function automatic logic [31:0] m_read(input logic [RW-1:0] code, input bit cur, input bit prv,
                                          input int size, input bit sex, input bit zex);
      int lane = int'(code[1:0]);
      int idx  = int'(code[3:2]);
      int bank = eff_bank(int'(code[5:4]), cur, prv);
      int w;
      logic [31:0] r, m;
      if (code[6]) r = (idx < NP) ? m_ptr[idx] : 32'h0;
      else         r = (idx < NA) ? m_acc[bank][idx] : 32'h0;
      if (size == 0)      begin r = r >> (8 * lane);        w = 8;  end
      else if (size == 1) begin r = r >> (16 * (lane / 2)); w = 16; end
      else                w = 32;
      if (w < 32 && (sex || zex)) begin
         m = (32'h1 << w) - 32'h1;
         r = r & m;
         if (sex && r[w-1]) r = r | ~m;
      end
      return r;
   endfunction

   function automatic logic [7:0] m_byte(input int i);
      int k = i / 4;
      logic [31:0] word;
      if (i == ND - 1) return 8'(m_rfp);
      if (k < NB * NA) word = m_acc[k / NA][k % NA];
      else             word = m_ptr[k - NB * NA];
      return 8'(word >> (8 * (i % 4)));
   endfunction

   task automatic model_step();
      int lane, idx, bank, sh;
      logic [31:0] mask;
      if (we && wr_size != 2'd3) begin
         lane = int'(wr_addr[1:0]); idx = int'(wr_addr[3:2]);
         bank = eff_bank(int'(wr_addr[5:4]), wr_cur, wr_prv);
         if (wr_size == 2'd0)      begin sh = 8 * lane;        mask = 32'hFF << sh;   end
         else if (wr_size == 2'd1) begin sh = 16 * (lane / 2); mask = 32'hFFFF << sh; end
         else                      begin sh = 0;               mask = 32'hFFFFFFFF;  end
         if (wr_addr[6]) begin
            if (idx < NP) m_ptr[idx] = (m_ptr[idx] & ~mask) | ((wr_data << sh) & mask);
         end else if (idx < NA) begin
            m_acc[bank][idx] = (m_acc[bank][idx] & ~mask) | ((wr_data << sh) & mask);
         end
      end
      if (rfp_ld)                m_rfp = int'(rfp_din);
      else if (rfp_inc != rfp_dec) m_rfp = (m_rfp + (rfp_inc ? 1 : NB - 1)) % NB;
      if (!m_busy) begin
         if (dmp_start) begin m_busy = 1'b1; m_idx = 0; end
      end else if (dmp_ready) begin
         if (m_idx == ND - 1) m_busy = 1'b0;
         else                 m_idx++;
      end
   endtask

   // One clock: check outputs against the model before the edge, then advance the model
   task automatic cycle();
      @(negedge clk);
      check("rd0", rd0_data, m_read(rd0_addr, rd0_cur, rd0_prv, int'(rd_size), rd_sex, rd_zex));
      check("rd1", rd1_data, m_read(rd1_addr, rd1_cur, rd1_prv, int'(rd_size), rd_sex, rd_zex));
      check("rfp", 32'(rfp), 32'(m_rfp));
      check("xsp", xsp, m_ptr[NP-1]);
      check("dmp_valid", 32'(dmp_valid), 32'(m_busy));
      check("dmp_busy", 32'(dmp_busy), 32'(m_busy));
      check("dmp_last", 32'(dmp_last), 32'(m_busy && m_idx == ND - 1));
      if (m_busy) check("dmp_dout", 32'(dmp_dout), 32'(m_byte(m_idx)));
      if (dmp_valid && dmp_ready) begin
         if (dmp_last) begin nlast++; lastpos = dq.size(); end
         dq.push_back(dmp_dout);
      end
      @(posedge clk);
      if (cen && !rst) model_step();
      #1;
   endtask

   task automatic run_dump();
      dq.delete(); nlast = 0; lastpos = -1;
      dmp_start = 1'b1; dmp_ready = 1'b0; cycle(); dmp_start = 1'b0;
      for (int t = 0; t < 400; t++) begin
         dmp_ready = t[0];
         dmp_start = (t == 10);
         cycle();
         if (!dmp_busy) break;
      end
      dmp_start = 1'b0; dmp_ready = 1'b0;
   endtask

   task automatic idle_inputs();
      cen = 1'b1; we = 1'b0; wr_addr = '0; wr_cur = 1'b0; wr_prv = 1'b0; wr_size = 2'd2; wr_data = 32'h0;
      rd0_addr = '0; rd1_addr = '0; rd0_cur = 1'b0; rd1_cur = 1'b0; rd0_prv = 1'b0; rd1_prv = 1'b0;
      rd_size = 2'd2; rd_sex = 1'b0; rd_zex = 1'b0; rfp_ld = 1'b0; rfp_din = 2'd0;
      rfp_inc = 1'b0; rfp_dec = 1'b0; dmp_start = 1'b0; dmp_ready = 1'b0;
   endtask

   initial begin
      int cnt, lcnt;
      idle_inputs();
      b_rd0_addr = '0; b_wr_addr = '0; b_wr_data = 32'h0; b_we = 1'b0; b_rfp_ld = 1'b0;
      b_rfp_din = 3'd0; b_rfp_inc = 1'b0; b_dmp_start = 1'b0; b_dmp_ready = 1'b0;
      rst = 1'b1; model_reset();
      @(posedge clk); @(posedge clk); #1; rst = 1'b0;

      // Reset state and a dump of it under 1/0 backpressure, with a stray start mid-dump
      check("xsp_rst", xsp, 32'h100);
      cycle();
      run_dump();
      check("dmp_len", 32'(dq.size()), 32'd81);
      check("dmp_nlast", 32'(nlast), 32'd1);
      check("dmp_lastpos", 32'(lastpos), 32'd80);
      foreach (dq[i]) check($sformatf("dmp_rst_byte%0d", i), 32'(dq[i]), (i == 77) ? 32'h1 : 32'h0);

      // Lane writes and extending reads
      we = 1'b1; wr_addr = {1'b0, 2'd1, 2'd2, 2'd0}; wr_size = 2'd2; wr_data = 32'h11223344; cycle();
      wr_addr = {1'b0, 2'd1, 2'd2, 2'd2}; wr_size = 2'd0; wr_data = 32'h000000AA; cycle();
      we = 1'b0;
      rd0_addr = {1'b0, 2'd1, 2'd2, 2'd0}; rd_size = 2'd2; #1;
      check("lane_long", rd0_data, 32'h11AA3344);
      rd1_addr = {1'b0, 2'd1, 2'd2, 2'd2}; rd_size = 2'd1; rd_sex = 1'b1; #1;
      check("word_sex", rd1_data, 32'h000011AA);
      rd_size = 2'd0; #1;
      check("byte_sex", rd1_data, 32'hFFFFFFAA);
      cycle();
      rd_sex = 1'b0; rd_size = 2'd2;

      // Bank pointer wrap and priority
      rfp_ld = 1'b1; rfp_din = 2'd3; cycle(); rfp_ld = 1'b0;
      rfp_inc = 1'b1; cycle(); check("rfp_inc_wrap", 32'(rfp), 32'd0);
      rfp_inc = 1'b0; rfp_dec = 1'b1; cycle(); check("rfp_dec_wrap", 32'(rfp), 32'd3);
      rfp_inc = 1'b1; cycle(); check("rfp_both", 32'(rfp), 32'd3);
      rfp_dec = 1'b0; rfp_ld = 1'b1; rfp_din = 2'd1; cycle(); check("rfp_ld_prio", 32'(rfp), 32'd1);
      rfp_ld = 1'b0; rfp_inc = 1'b0;

      // Current / previous bank substitution
      rfp_ld = 1'b1; rfp_din = 2'd0; cycle(); rfp_ld = 1'b0;
      we = 1'b1; wr_prv = 1'b1; wr_addr = {1'b0, 2'd1, 2'd0, 2'd0}; wr_data = 32'd5; cycle();
      we = 1'b0; wr_prv = 1'b0;
      rd0_addr = {1'b0, 2'd2, 2'd0, 2'd0}; rd0_cur = 1'b1; #1; check("rd_cur", rd0_data, 32'd0);
      rd0_cur = 1'b0; rd0_prv = 1'b1; #1; check("rd_prv", rd0_data, 32'd5);
      rd0_prv = 1'b0;
      cycle();

      // Dump with non-zero content and status byte
      rfp_ld = 1'b1; rfp_din = 2'd2; cycle(); rfp_ld = 1'b0;
      run_dump();
      check("dmp2_len", 32'(dq.size()), 32'd81);
      if (dq.size() > 0) check("dmp2_status", 32'(dq[dq.size()-1]), 32'd2);

      // Reset mid-dump drops valid without waiting for an edge
      dmp_start = 1'b1; cycle(); dmp_start = 1'b0; dmp_ready = 1'b1; cycle(); cycle();
      rst = 1'b1; #1;
      check("rst_mid_valid", 32'(dmp_valid), 32'd0);
      check("rst_mid_busy", 32'(dmp_busy), 32'd0);
      model_reset(); cycle(); rst = 1'b0; cycle(); cycle();
      dmp_ready = 1'b0;

      // Randomized traffic against the model
      for (int t = 0; t < 3000; t++) begin
         cen       = ($urandom_range(0, 9) != 0);
         we        = 1'($urandom_range(0, 1));
         wr_addr   = RW'($urandom);
         wr_size   = 2'($urandom);
         wr_cur    = ($urandom_range(0, 3) == 0);
         wr_prv    = ($urandom_range(0, 3) == 0);
         wr_data   = $urandom;
         rd0_addr  = RW'($urandom);
         rd1_addr  = RW'($urandom);
         rd0_cur   = ($urandom_range(0, 3) == 0);
         rd1_cur   = ($urandom_range(0, 3) == 0);
         rd0_prv   = ($urandom_range(0, 3) == 0);
         rd1_prv   = ($urandom_range(0, 3) == 0);
         rd_size   = 2'($urandom_range(0, 2));
         rd_sex    = 1'($urandom_range(0, 1));
         rd_zex    = 1'($urandom_range(0, 1));
         rfp_ld    = ($urandom_range(0, 15) == 0);
         rfp_din   = 2'($urandom);
         rfp_inc   = ($urandom_range(0, 3) == 0);
         rfp_dec   = ($urandom_range(0, 3) == 0);
         dmp_start = ($urandom_range(0, 19) == 0);
         dmp_ready = 1'($urandom_range(0, 1));
         cycle();
      end
      idle_inputs();

      // Non-default geometry: 8 banks, 8 accumulators, 2 pointers
      b_rfp_ld = 1'b1; b_rfp_din = 3'd7; @(posedge clk); #1; b_rfp_ld = 1'b0;
      check("b_rfp_ld", 32'(b_rfp), 32'd7);
      b_rfp_inc = 1'b1; @(posedge clk); #1; b_rfp_inc = 1'b0;
      check("b_rfp_wrap", 32'(b_rfp), 32'd0);
      b_we = 1'b1; b_wr_addr = {1'b1, 3'd0, 3'd3, 2'd0}; b_wr_data = 32'hDEADBEEF;
      @(posedge clk); #1; b_we = 1'b0;
      b_rd0_addr = {1'b1, 3'd0, 3'd3, 2'd0}; #1;
      check("b_ptr_oob", b_rd0_data, 32'h0);
      check("b_xsp", b_xsp, 32'h100);
      b_dmp_start = 1'b1; @(posedge clk); #1; b_dmp_start = 1'b0; b_dmp_ready = 1'b1;
      cnt = 0; lcnt = 0;
      for (int t = 0; t < 600; t++) begin
         @(negedge clk);
         if (b_dmp_valid && b_dmp_ready) begin
            cnt++;
            if (b_dmp_last) lcnt++;
         end
         @(posedge clk); #1;
         if (!b_dmp_busy) break;
      end
      check("b_dmp_len", 32'(cnt), 32'd265);
      check("b_dmp_nlast", 32'(lcnt), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
